ram_delay_mc: RTL
=================

// Module: ram_delay_mc
// PURPOSE
//  Multi-channel, RAM-based programmable delay line. P_NCHAN channels of P_NBITS_DATA share
//  one circular buffer and one write pointer. All channels get an identical delay, counted
//  in accepted write strobes. Adds an output strobe, a sample-exact valid flag, a flush
//  input and automatic re-prime on delay change. Used between ADC capture and trigger logic
//  so pre-trigger samples stay available.
// PARAMETERS
//  P_NBITS_ADDR  8   RAM address width; depth = 2**P_NBITS_ADDR; max delay = 2**P_NBITS_ADDR-1
//  P_NBITS_DATA  14  bits per channel sample
//  P_NCHAN       4   channel count; RAM word width = P_NCHAN*P_NBITS_DATA
// PORTS
//  clk        in   1                     clock; the only clock
//  rst        in   1                     reset, asynchronous, active-high
//  delay_len  in   P_NBITS_ADDR          delay D in writes; 0 is clamped to 1
//  flush      in   1                     pulse: discard history, re-prime
//  wr         in   1                     write strobe; d is accepted when high
//  d          in   P_NCHAN*P_NBITS_DATA  input samples; channel n = d[n*P_NBITS_DATA +: P_NBITS_DATA]
//  q          out  P_NCHAN*P_NBITS_DATA  delayed samples; same packing as d
//  q_wr       out  1                     pulses once per accepted wr, 1 clk later
//  valid      out  1                     high with q_wr when q is a real sample from D writes earlier
//  delay_err  out  1                     registered flag: delay_len==0 (clamp active)
// BEHAVIOUR
//  Reset values (async): wp=0, cnt=0, state=FILL, d_reg=0, q=0, q_wr=0, valid=0, delay_err=0.
//  D_eff = (d_reg==0) ? 1 : d_reg. d_reg is the registered copy of delay_len.
//  Datapath:
//   - On wr: RAM[wp] <= d, wp <= wp+1 (wraps mod 2**P_NBITS_ADDR).
//   - Same cycle: sync read of RAM[wp-D_eff] (mod depth).
//   - Read and write addresses always differ, so there is no read-during-write hazard.
//  Outputs, one clock after an accepted wr:
//   - q_wr=1; valid=(state==RUN at the wr).
//   - q = RAM data if valid, else 0. q holds between strobes.
//  Latency:
//   - With k counting writes since the last restart, the sample written at write k appears
//     at the q_wr of write k+D_eff, 1 clk after that wr.
//  Restart condition: flush==1 OR delay_len!=d_reg. Evaluated every clock, wr or not.
//   - Restart effect: d_reg<=delay_len, cnt<=0, state<=FILL; wp is NOT reset.
//   - A wr in the restart cycle is still written and still produces q_wr, with valid=0.
//     It is not counted.
//   - The first clock after reset always performs a restart unless delay_len==0; the
//     restart is harmless.
//  FSM (2 states):
//   - FILL: each counted wr does cnt<=cnt+1. A wr with cnt==D_eff-1 moves to RUN.
//     Every wr output in FILL has valid=0.
//   - RUN: every wr output has valid=1. Stay in RUN until a restart.
//   - Restart overrides the FILL->RUN transition in the same cycle.
//   - cnt is P_NBITS_ADDR wide and never exceeds D_eff-1.
//  delay_err <= (delay_len==0) each clock.
//  No wr -> no pointer or counter movement and no q_wr. Gaps between wr are arbitrary.
//  rst mid-stream:
//   - Outputs clear immediately.
//   - RAM contents are not cleared; they are unreachable until refilled, because valid=0.
// TESTING
//  1. P_NCHAN=4, D=5: wr every clk, ch n = 16*k+n.
//     -> first valid at write 6 (k=5, q_wr 1 clk later), q = sample k=0. Then continuous,
//     each q = sample k-5.
//  2. D=3, wr every 3rd clk -> q_wr exactly 1 clk after each wr. valid from the 4th wr.
//     q equals the sample from 3 wr earlier; gaps do not shift the data.
//  3. RUN at D=4; change delay_len to 7 (concurrent wr in that cycle)
//     -> that output has valid=0. The next 7 outputs are invalid; the 8th valid=1 and equals
//     the first wr after the change.
//  4. flush pulse during RUN with D=2 -> valid low for 2 wr, then valid. q=0 while invalid.
//  5. delay_len=0 -> delay_err=1 and behaves as D=1. Set delay_len=2**P_NBITS_ADDR-1
//     (255) -> after 255 fill writes, data intact across pointer wrap for 600 writes.
//  6. Assert rst asynchronously mid-RUN -> q, q_wr, valid go 0 without a clk edge. After
//     release, D writes are needed before valid=1.

Source files
------------

// File: rtl/ram_delay_mc.sv
// ram_delay_mc: multi-channel programmable delay line built on one circular RAM.
// All channels share the write pointer, so a single delay applies to every lane.
// Outputs are valid only once D_eff writes have landed since the last restart.
// Until then, q reads as zero rather than stale RAM contents.
//
//  state | meaning
//  ------+-----------------------------------------------------------------
//  FILL  | priming after reset/flush/delay change; outputs flagged invalid
//  RUN   | at least D_eff writes buffered; every output is a real sample

module ram_delay_mc #(
    parameter int P_NBITS_ADDR = 8,
    parameter int P_NBITS_DATA = 14,
    parameter int P_NCHAN      = 4
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic [P_NBITS_ADDR-1:0]           delay_len,
    input  logic                              flush,
    input  logic                              wr,
    input  logic [P_NCHAN*P_NBITS_DATA-1:0]   d,
    output logic [P_NCHAN*P_NBITS_DATA-1:0]   q,
    output logic                              q_wr,
    output logic                              valid,
    output logic                              delay_err
);

    localparam int LP_W     = P_NCHAN * P_NBITS_DATA;
    localparam int LP_DEPTH = 2 ** P_NBITS_ADDR;

    typedef enum logic {
        ST_FILL = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    state_t                  r_state;
    state_t                  w_state_nxt;
    logic [P_NBITS_ADDR-1:0] r_cnt;
    logic [P_NBITS_ADDR-1:0] w_cnt_nxt;
    logic [P_NBITS_ADDR-1:0] r_wp;
    logic [P_NBITS_ADDR-1:0] r_d_reg;
    logic [P_NBITS_ADDR-1:0] w_d_eff;
    logic [P_NBITS_ADDR-1:0] w_d_eff_m1;
    logic [P_NBITS_ADDR-1:0] w_rd_addr;
    logic                    w_restart;
    logic                    w_valid_now;
    logic [LP_W-1:0]         r_q;
    logic                    r_q_wr;
    logic                    r_valid;
    logic                    r_delay_err;
    logic [LP_W-1:0]         r_ram [LP_DEPTH];

    // A zero delay would make read and write collide, so it is treated as one.
    assign w_d_eff     = (r_d_reg == '0) ? {{(P_NBITS_ADDR-1){1'b0}}, 1'b1} : r_d_reg;
    assign w_d_eff_m1  = w_d_eff - {{(P_NBITS_ADDR-1){1'b0}}, 1'b1};
    assign w_rd_addr   = r_wp - w_d_eff;
    assign w_restart   = flush | (delay_len != r_d_reg);
    // A write in a restart cycle is never valid, even when the FSM is in RUN.
    assign w_valid_now = (r_state == ST_RUN) & ~w_restart;

    // FSM state and fill counter register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_FILL;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    // Next-state logic: restart wins over fill progress; only counted writes advance
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        if (w_restart) begin
            w_state_nxt = ST_FILL;
            w_cnt_nxt   = '0;
        end else if (wr) begin
            case (r_state)
                ST_FILL: begin
                    // Counter holds at D_eff-1 on the transition, so it never exceeds it.
                    if (r_cnt == w_d_eff_m1) begin
                        w_state_nxt = ST_RUN;
                    end else begin
                        w_cnt_nxt = r_cnt + {{(P_NBITS_ADDR-1){1'b0}}, 1'b1};
                    end
                end
                ST_RUN: begin
                    w_state_nxt = ST_RUN;
                end
                default: begin
                    w_state_nxt = ST_FILL;
                end
            endcase
        end
    end

    // Pointer, delay register, and output strobes; the q read is synchronous with the write
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wp        <= '0;
            r_d_reg     <= '0;
            r_q         <= '0;
            r_q_wr      <= 1'b0;
            r_valid     <= 1'b0;
            r_delay_err <= 1'b0;
        end else begin
            r_d_reg     <= delay_len;
            r_delay_err <= (delay_len == '0);
            r_q_wr      <= wr;
            r_valid     <= wr & w_valid_now;
            if (wr) begin
                r_wp <= r_wp + {{(P_NBITS_ADDR-1){1'b0}}, 1'b1};
                r_q  <= w_valid_now ? r_ram[w_rd_addr] : '0;
            end
        end
    end

    // Sample RAM write port; contents survive reset and are gated by valid instead
    always_ff @(posedge clk) begin
        if (wr) begin
            r_ram[r_wp] <= d;
        end
    end

    assign q         = r_q;
    assign q_wr      = r_q_wr;
    assign valid     = r_valid;
    assign delay_err = r_delay_err;

endmodule
